e_digit_streamer: RTL and testbench

Reader for the 400-bit fixed-point result produced by the e calculator.
- Latches the binary value on a start pulse, then converts it to decimal.
- Emits the integer digit followed by NUM_DIGITS fractional digits, one per valid/ready beat, using repeated multiply-by-10.
- Sits between the calculator's ans/done outputs and a display/UART sink.

---
 rtl/e_digit_streamer.sv | 122 ++++++++++++
 tb/tb_e_digit_streamer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e_digit_streamer.sv
// rtl/e_digit_streamer.sv - binary fixed-point to decimal digit streamer (option: DIGIT_ASCII_EN)
module e_digit_streamer #(
    parameter int WIDTH      = 400,
    parameter int FRAC_BITS  = 392,
    parameter int NUM_DIGITS = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in_value,
    output logic             busy,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic [7:0]       digit_data,
    output logic             digit_last,
    output logic             int_err,
    output logic             done
);

    localparam int IW = WIDTH - FRAC_BITS;
    localparam logic [7:0] LAST_CNT = 8'(NUM_DIGITS - 1);
`ifdef DIGIT_ASCII_EN
    localparam logic [7:0] ERR_CHAR = 8'h3F;
`else
    localparam logic [7:0] ERR_CHAR = 8'h0F;
`endif

    typedef enum logic [2:0] {IDLE, INT, DOT, FRAC, FIN} state_t;

    state_t               state;
    logic [FRAC_BITS-1:0] frac_reg;
    logic [7:0]           cnt;
    logic [FRAC_BITS+3:0] prod;
    logic [IW-1:0]        ipart;

    // frac_reg holds the remainder left after the digit currently presented
    assign prod  = ({4'b0, frac_reg} << 3) + ({4'b0, frac_reg} << 1);
    assign ipart = in_value[WIDTH-1:FRAC_BITS];

    function automatic logic [7:0] enc(input logic [3:0] d);
`ifdef DIGIT_ASCII_EN
        return 8'h30 + {4'h0, d};
`else
        return {4'h0, d};
`endif
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            frac_reg    <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            digit_valid <= 1'b0;
            digit_data  <= '0;
            digit_last  <= 1'b0;
            int_err     <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        frac_reg    <= in_value[FRAC_BITS-1:0];
                        cnt         <= '0;
                        busy        <= 1'b1;
                        digit_valid <= 1'b1;
                        digit_last  <= 1'b0;
                        state       <= INT;
                        if (ipart > IW'(9)) begin
                            int_err    <= 1'b1;
                            digit_data <= ERR_CHAR;
                        end else begin
                            int_err    <= 1'b0;
                            digit_data <= enc(ipart[3:0]);
                        end
                    end
                end
                INT: begin
                    if (digit_ready) begin
`ifdef DIGIT_ASCII_EN
                        digit_data <= 8'h2E;
                        state      <= DOT;
`else
                        digit_data <= enc(prod[FRAC_BITS+3:FRAC_BITS]);
                        frac_reg   <= prod[FRAC_BITS-1:0];
                        digit_last <= (LAST_CNT == 8'd0);
                        state      <= FRAC;
`endif
                    end
                end
                DOT: begin
                    if (digit_ready) begin
                        digit_data <= enc(prod[FRAC_BITS+3:FRAC_BITS]);
                        frac_reg   <= prod[FRAC_BITS-1:0];
                        digit_last <= (LAST_CNT == 8'd0);
                        state      <= FRAC;
                    end
                end
                FRAC: begin
                    if (digit_ready) begin
                        if (digit_last) begin
                            digit_valid <= 1'b0;
                            digit_last  <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= FIN;
                        end else begin
                            digit_data <= enc(prod[FRAC_BITS+3:FRAC_BITS]);
                            frac_reg   <= prod[FRAC_BITS-1:0];
                            cnt        <= cnt + 8'd1;
                            digit_last <= (cnt + 8'd1 == LAST_CNT);
                        end
                    end
                end
                FIN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_e_digit_streamer.sv
// tb/tb_e_digit_streamer.sv - scoreboard bench for e_digit_streamer (small config plus default config)
module tb_e_digit_streamer;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in_value;
    logic        busy, digit_valid, digit_ready, digit_last, int_err, done;
    logic [7:0]  digit_data;

    logic         start_b;
    logic [399:0] in_b;
    logic         busy_b, valid_b, ready_b, last_b, err_b, done_b;
    logic [7:0]   data_b;

    int total = 0;
    int bad = 0;
    int mode = 0;
    int phase = 0;
    int beat_cnt = 0;
    int beats_b = 0;
    beat_t exp_q[$];
    beat_t exp_b[$];
    logic exp_err = 1'b0;
    logic held_v = 1'b0;
    logic [7:0] held_d;
    logic held_l;
    logic pend_done = 1'b0;

    e_digit_streamer #(.WIDTH(16), .FRAC_BITS(8), .NUM_DIGITS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .in_value(in_value), .busy(busy),
        .digit_valid(digit_valid), .digit_ready(digit_ready), .digit_data(digit_data),
        .digit_last(digit_last), .int_err(int_err), .done(done)
    );

    e_digit_streamer dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_value(in_b), .busy(busy_b),
        .digit_valid(valid_b), .digit_ready(ready_b), .digit_data(data_b),
        .digit_last(last_b), .int_err(err_b), .done(done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] enc(input int d);
`ifdef DIGIT_ASCII_EN
        return 8'(8'h30 + d);
`else
        return 8'(d);
`endif
    endfunction

    // Decimal expansion of v/256: k-th fractional digit = floor(frac * 10^k / 256) mod 10
    function automatic void model(input logic [15:0] v);
        longint f, p, d;
        int ip;
        ip = int'(v[15:8]);
        f  = longint'(v[7:0]);
        exp_err = (ip > 9);
`ifdef DIGIT_ASCII_EN
        exp_q.push_back('{data: exp_err ? 8'h3F : enc(ip), last: 1'b0});
        exp_q.push_back('{data: 8'h2E, last: 1'b0});
`else
        exp_q.push_back('{data: exp_err ? 8'h0F : enc(ip), last: 1'b0});
`endif
        p = 1;
        for (int k = 1; k <= 4; k++) begin
            p = p * 10;
            d = ((f * p) / 256) % 10;
            exp_q.push_back('{data: enc(int'(d)), last: (k == 4)});
        end
    endfunction

    initial begin
        digit_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: digit_ready = 1'b1;
                1: begin
                    digit_ready = (phase == 0);
                    phase = (phase + 1) % 3;
                end
                default: digit_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            held_v    = 1'b0;
            pend_done = 1'b0;
        end else begin
            if (pend_done) begin
                chk("done_after_last", done, 1'b1);
                chk("busy_low_at_done", busy, 1'b0);
                pend_done = 1'b0;
            end
            if (done && busy) chk("done_busy_exclusive", 1'b1, 1'b0);
            if (digit_valid) begin
                if (held_v) begin
                    chk("stall_data_hold", digit_data, held_d);
                    chk("stall_last_hold", digit_last, held_l);
                end
                if (digit_ready) begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 1'b1, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("digit_data", digit_data, e.data);
                        chk("digit_last", digit_last, e.last);
                        chk("int_err", int_err, exp_err);
                        beat_cnt++;
                        if (e.last) pend_done = 1'b1;
                    end
                end else begin
                    held_v = 1'b1;
                    held_d = digit_data;
                    held_l = digit_last;
                end
            end else if (held_v) begin
                chk("valid_dropped_before_beat", 1'b0, 1'b1);
                held_v = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst && valid_b && ready_b) begin
            if (exp_b.size() == 0) begin
                chk("b_unexpected_beat", 1'b1, 1'b0);
            end else begin
                e = exp_b.pop_front();
                if (data_b !== e.data || last_b !== e.last)
                    chk("b_digit", {data_b, last_b}, {e.data, e.last});
                else
                    total++;
                beats_b++;
            end
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        chk("done_seen", done, 1'b1);
    endtask

    task automatic run(input logic [15:0] v, input int m);
        mode  = m;
        phase = 0;
        model(v);
        @(posedge clk);
        #1;
        start    = 1'b1;
        in_value = v;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_value = 16'($urandom);
        chk("busy_after_start", busy, 1'b1);
        chk("valid_after_start", digit_valid, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        start    = 1'b1;
        in_value = ~v;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        start    = 1'b1;
        in_value = 16'h0500;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("fin_start_ignored_busy", busy, 1'b0);
        chk("fin_start_ignored_valid", digit_valid, 1'b0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_value = '0;
        start_b = 1'b0;
        in_b = '0;
        ready_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {busy, digit_valid, digit_data, digit_last, int_err, done}, '0);
        chk("rst_state_b", {busy_b, valid_b, data_b, last_b, err_b, done_b}, '0);
        rst = 1'b0;

        exp_b.push_back('{data: enc(1), last: 1'b0});
`ifdef DIGIT_ASCII_EN
        exp_b.push_back('{data: 8'h2E, last: 1'b0});
`endif
        for (int k = 1; k <= 100; k++) exp_b.push_back('{data: enc(0), last: (k == 100)});
        @(posedge clk);
        #1;
        start_b = 1'b1;
        in_b    = 400'd1 << 392;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (done_b) break;
        end
        chk("b_done_seen", done_b, 1'b1);
        chk("b_busy_low_at_done", busy_b, 1'b0);
        @(posedge clk);
        #1;
        chk("b_busy_after_done", busy_b, 1'b0);
        chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
`ifdef DIGIT_ASCII_EN
        chk("b_beat_count", 32'(beats_b), 32'd102);
`else
        chk("b_beat_count", 32'(beats_b), 32'd101);
`endif

        run(16'h01C0, 0);
        run(16'h0140, 1);
        run(16'h0C00, 2);
        run(16'h0140, 0);
        run(16'h0000, 1);
        run(16'h09FF, 2);

        mode = 0;
        model(16'h01C0);
        @(posedge clk);
        #1;
        beat_cnt = 0;
        start    = 1'b1;
        in_value = 16'h01C0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (beat_cnt >= 2) break;
            @(posedge clk);
            #1;
        end
        chk("two_beats_before_rst", 32'(beat_cnt), 32'd2);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("mid_stream_rst", {busy, digit_valid, digit_data, digit_last, int_err, done}, '0);
        rst = 1'b0;
        run(16'h01C0, 0);

        for (int n = 0; n < 10; n++)
            run({8'($urandom_range(0, 11)), 8'($urandom)}, int'($urandom_range(0, 2)));

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
